kb_ascii_stream: RTL
====================

# kb_ascii_stream

Sequential successor to the combinational scan-code-to-ASCII lookup. The block consumes raw PS/2 Set-2 scan bytes from the keyboard receiver and decodes break (F0) and extended (E0) prefixes. It tracks left/right shift and caps lock internally and pushes shift/caps-aware ASCII characters into a parametrised FIFO for the text/video consumer. It sits between the PS/2 receiver and the character-writer logic.

## Interface
- FIFO_AW, 4, log2 of character FIFO depth (depth = 2**FIFO_AW)
- DROP_UNKNOWN, 0, 1 = discard unmapped make codes; 0 = push UNKNOWN_CHAR
- UNKNOWN_CHAR, 8'h2A, character pushed for unmapped make codes
- clk  in  1  system clock; single clock domain
- rst  in  1  reset; synchronous, active-high
- scan_valid  in  1  one-cycle strobe, scan_code valid
- scan_code  in  8  raw scan byte from PS/2 receiver
- rd_en  in  1  pop head character (ignored when empty)
- ascii_out  out  8  FIFO head (first-word-fall-through); 8'h00 when empty
- empty  out  1  FIFO empty
- full  out  1  FIFO full
- overflow  out  1  sticky; set when a character is dropped because FIFO full; cleared only by rst
- shift_o  out  1  shift_l | shift_r
- caps_o  out  1  caps-lock state

## Operation
- Decoder FSM states: IDLE, BRK (after F0), EXT (after E0), EXT_BRK (after E0 F0). Advances only on scan_valid.
- IDLE transitions:
  - F0 -> BRK
  - E0 -> EXT
  - any other byte is a make code; process it, stay IDLE
- BRK: byte is a break code; 12 clears shift_l, 59 clears shift_r, 58 clears caps_held; nothing pushed; -> IDLE. F0 repeated stays BRK.
- EXT: F0 -> EXT_BRK; E0 stays EXT; 5A pushes 8'h0D, 4A pushes 8'h2F; any other byte discarded; -> IDLE.
- EXT_BRK: any byte discarded -> IDLE.
- Make handling:
  - 12 sets shift_l; 59 sets shift_r.
  - 58 toggles caps only if caps_held = 0, then sets caps_held, so typematic repeats do not re-toggle.
  - Ignored silently: 11, 14, 77, E1, AA, FA, FE.
  - Letters: uppercase when shift_o XOR caps_o, else lowercase.
  - Digits/punctuation: use the shifted map when shift_o, independent of caps. Shifted map is 16 !, 1E @, 26 #, 25 $, 2E %, 36 ^, 3D &, 3E *, 46 (, 45 ), 0E ~, 4E _, 55 +, 54 {, 5B }, 5D |, 4C :, 52 ", 41 <, 49 >, 4A ?.
  - 29 space, 5A 0D, 66 08: unaffected by shift or caps.
  - Unmapped make: push UNKNOWN_CHAR, or nothing if DROP_UNKNOWN = 1.
- Typematic repeats of printable makes push again; this is intended auto-repeat.

## Timing
- Character push occurs on the clk edge that samples scan_valid. empty deasserts the cycle after that edge, so latency is 1 cycle.
- Shift/caps updates take effect on the same edge. The next byte sees the new state.
- Pop on rd_en & !empty. ascii_out shows the next entry the following cycle.
- Push and pop in the same cycle:
  - when not empty, count is unchanged
  - when full, both succeed and overflow stays unchanged
  - when empty, the push succeeds and the pop is ignored
- Push while full with no pop: character dropped, overflow set, pointers unchanged.
- Pointers wrap modulo 2**FIFO_AW. Count is FIFO_AW+1 bits; full = count == 2**FIFO_AW.
- Reset values:
  - FSM = IDLE
  - shift_l, shift_r, caps, caps_held = 0
  - pointers and count = 0
  - empty = 1, full = 0, overflow = 0, ascii_out = 00, shift_o = 0, caps_o = 0
- rst mid-sequence (e.g. after E0) abandons the prefix; the next byte is decoded from IDLE.

## Structure
- Package kb_pkg holds:
  - FSM state enum
  - scan constants: SC_BRK=F0, SC_EXT=E0, SC_LSHIFT=12, SC_RSHIFT=59, SC_CAPS=58
  - function keymap(code, shift, caps) returning {hit, ascii}
- One sub-module: kb_char_fifo, a parametrised FWFT synchronous FIFO with push, pop, full, empty and drop flag.

## Test plan
- Reset, then make 1C with shift/caps 0: one cycle later empty=0, ascii_out=61; rd_en pulse -> empty=1, ascii_out=00.
- Sequence 12, 1C, 16, F0 12, 1C: FIFO holds 41, 21, 61; shift_o=1 after 12 and 0 after F0 12.
- Caps: 58, 58 (repeat), F0 58, 1C, 12, 1C: caps_o=1 after the first 58, still 1 after the repeat; FIFO holds 41, 61.
- Extended: E0 5A, E0 4A, E0 75, E0 F0 75: FIFO holds 0D, 2F only; FSM returns to IDLE.
- FIFO_AW=2: push 5 makes with no reads -> full=1 after the 4th, 5th dropped, overflow=1. Then push and pop in the same cycle while full -> count stays 4.
- Unknown make 07 with DROP_UNKNOWN=0 pushes 2A, with DROP_UNKNOWN=1 pushes nothing. rst asserted after E0, then 1C -> pushes 61.

Source files
------------

// File: rtl/kb_ascii_stream_pkg.sv
// Shared types, scan constants and the Set-2 keymap for the PS/2 ASCII stream.
package kb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BRK,
        ST_EXT,
        ST_EXT_BRK
    } kb_state_t;

    localparam logic [7:0] SC_BRK    = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CAPS   = 8'h58;

    // Make codes that are consumed without producing a character
    // (modifiers handled by the FSM, ctrl/alt, num lock, protocol replies).
    function automatic logic is_silent(input logic [7:0] code);
        case (code)
            SC_LSHIFT, SC_RSHIFT, SC_CAPS,
            8'h11, 8'h14, 8'h77, 8'hE1, 8'hAA, 8'hFA, 8'hFE: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Returns {hit, ascii}. Letters follow shift ^ caps; everything else
    // follows shift only.
    function automatic logic [8:0] keymap(input logic [7:0] code,
                                          input logic shift,
                                          input logic caps);
        logic [7:0] lower;
        logic [7:0] base;
        logic [7:0] shifted;
        logic       hit;
        lower   = '0;
        base    = '0;
        shifted = '0;
        hit     = 1'b1;
        case (code)
            8'h1C: lower = "a";  8'h32: lower = "b";  8'h21: lower = "c";
            8'h23: lower = "d";  8'h24: lower = "e";  8'h2B: lower = "f";
            8'h34: lower = "g";  8'h33: lower = "h";  8'h43: lower = "i";
            8'h3B: lower = "j";  8'h42: lower = "k";  8'h4B: lower = "l";
            8'h3A: lower = "m";  8'h31: lower = "n";  8'h44: lower = "o";
            8'h4D: lower = "p";  8'h15: lower = "q";  8'h2D: lower = "r";
            8'h1B: lower = "s";  8'h2C: lower = "t";  8'h3C: lower = "u";
            8'h2A: lower = "v";  8'h1D: lower = "w";  8'h22: lower = "x";
            8'h35: lower = "y";  8'h1A: lower = "z";
            default: lower = '0;
        endcase
        if (lower != '0) begin
            return {1'b1, (shift ^ caps) ? (lower - 8'h20) : lower};
        end
        case (code)
            8'h45: begin base = "0";   shifted = ")";  end
            8'h16: begin base = "1";   shifted = "!";  end
            8'h1E: begin base = "2";   shifted = "@";  end
            8'h26: begin base = "3";   shifted = "#";  end
            8'h25: begin base = "4";   shifted = "$";  end
            8'h2E: begin base = "5";   shifted = "%";  end
            8'h36: begin base = "6";   shifted = "^";  end
            8'h3D: begin base = "7";   shifted = "&";  end
            8'h3E: begin base = "8";   shifted = "*";  end
            8'h46: begin base = "9";   shifted = "(";  end
            8'h0E: begin base = 8'h60; shifted = "~";  end
            8'h4E: begin base = "-";   shifted = "_";  end
            8'h55: begin base = "=";   shifted = "+";  end
            8'h54: begin base = "[";   shifted = "{";  end
            8'h5B: begin base = "]";   shifted = "}";  end
            8'h5D: begin base = "\\";  shifted = "|";  end
            8'h4C: begin base = ";";   shifted = ":";  end
            8'h52: begin base = "'";   shifted = "\""; end
            8'h41: begin base = ",";   shifted = "<";  end
            8'h49: begin base = ".";   shifted = ">";  end
            8'h4A: begin base = "/";   shifted = "?";  end
            8'h29: begin base = " ";   shifted = " ";  end
            8'h5A: begin base = 8'h0D; shifted = 8'h0D; end
            8'h66: begin base = 8'h08; shifted = 8'h08; end
            default: hit = 1'b0;
        endcase
        return {hit, shift ? shifted : base};
    endfunction

endpackage

// File: rtl/kb_ascii_stream_if.sv
// Scan-byte input and character-FIFO output bundle of kb_ascii_stream.
interface kb_ascii_stream_if;
    logic       scan_valid;
    logic [7:0] scan_code;
    logic       rd_en;
    logic [7:0] ascii_out;
    logic       empty;
    logic       full;
    logic       overflow;
    logic       shift_o;
    logic       caps_o;

    modport slave (
        input  scan_valid, scan_code, rd_en,
        output ascii_out, empty, full, overflow, shift_o, caps_o
    );

    modport master (
        output scan_valid, scan_code, rd_en,
        input  ascii_out, empty, full, overflow, shift_o, caps_o
    );
endinterface

// File: rtl/kb_ascii_stream_fifo.sv
// First-word-fall-through character FIFO with a sticky drop flag.
module kb_char_fifo #(
    parameter int unsigned AW = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [7:0] dout,
    output logic       empty,
    output logic       full,
    output logic       drop
);
    localparam logic [AW:0]   DEPTH   = (AW+1)'(2**AW);
    localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [7:0]    mem [2**AW];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == DEPTH);
    assign do_pop  = pop & ~empty;
    // A pop frees the slot this edge, so a push into a full FIFO still lands.
    assign do_push = push & (~full | do_pop);
    assign dout    = empty ? '0 : mem[rd_ptr];

    // Storage write; contents need no reset since dout is gated by empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer, occupancy and sticky drop bookkeeping.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            drop   <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            if (push && !do_push) drop <= 1'b1;
        end
    end
endmodule

// File: rtl/kb_ascii_stream.sv
// PS/2 Set-2 scan byte decoder pushing shift/caps-aware ASCII into a FIFO.
module kb_ascii_stream #(
    parameter int unsigned FIFO_AW      = 4,
    parameter bit          DROP_UNKNOWN = 1'b0,
    parameter logic [7:0]  UNKNOWN_CHAR = 8'h2A
) (
    input logic              clk,
    input logic              rst,
    kb_ascii_stream_if.slave bus
);
    import kb_pkg::*;

    kb_state_t  state;
    logic       shift_l;
    logic       shift_r;
    logic       caps;
    logic       caps_held;
    logic       shift_any;
    logic       push;
    logic [7:0] push_char;
    logic [8:0] km;

    assign shift_any   = shift_l | shift_r;
    assign bus.shift_o = shift_any;
    assign bus.caps_o  = caps;

    // Character produced by the byte being sampled this edge.
    always_comb begin
        push      = 1'b0;
        push_char = '0;
        km        = keymap(bus.scan_code, shift_any, caps);
        if (bus.scan_valid) begin
            case (state)
                ST_IDLE: begin
                    if (bus.scan_code != SC_BRK && bus.scan_code != SC_EXT &&
                        !is_silent(bus.scan_code)) begin
                        if (km[8]) begin
                            push      = 1'b1;
                            push_char = km[7:0];
                        end else if (!DROP_UNKNOWN) begin
                            push      = 1'b1;
                            push_char = UNKNOWN_CHAR;
                        end
                    end
                end
                ST_EXT: begin
                    if (bus.scan_code == 8'h5A) begin
                        push      = 1'b1;
                        push_char = 8'h0D;
                    end else if (bus.scan_code == 8'h4A) begin
                        push      = 1'b1;
                        push_char = 8'h2F;
                    end
                end
                default: ;
            endcase
        end
    end

    // Prefix decoder and modifier state, advancing only on scan_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            shift_l   <= 1'b0;
            shift_r   <= 1'b0;
            caps      <= 1'b0;
            caps_held <= 1'b0;
        end else if (bus.scan_valid) begin
            case (state)
                ST_IDLE: begin
                    if (bus.scan_code == SC_BRK) begin
                        state <= ST_BRK;
                    end else if (bus.scan_code == SC_EXT) begin
                        state <= ST_EXT;
                    end else begin
                        if (bus.scan_code == SC_LSHIFT) shift_l <= 1'b1;
                        if (bus.scan_code == SC_RSHIFT) shift_r <= 1'b1;
                        // caps_held suppresses re-toggling on typematic repeats.
                        if (bus.scan_code == SC_CAPS) begin
                            if (!caps_held) caps <= ~caps;
                            caps_held <= 1'b1;
                        end
                    end
                end
                ST_BRK: begin
                    if (bus.scan_code != SC_BRK) begin
                        if (bus.scan_code == SC_LSHIFT) shift_l   <= 1'b0;
                        if (bus.scan_code == SC_RSHIFT) shift_r   <= 1'b0;
                        if (bus.scan_code == SC_CAPS)   caps_held <= 1'b0;
                        state <= ST_IDLE;
                    end
                end
                ST_EXT: begin
                    if (bus.scan_code == SC_BRK)      state <= ST_EXT_BRK;
                    else if (bus.scan_code != SC_EXT) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    kb_char_fifo #(.AW(FIFO_AW)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .din   (push_char),
        .pop   (bus.rd_en),
        .dout  (bus.ascii_out),
        .empty (bus.empty),
        .full  (bus.full),
        .drop  (bus.overflow)
    );
endmodule
